// File: rtl/token_pkg.sv
// Shared encodings, widths and default screen geometry for the token move renderer.
package token_pkg;

  localparam int X_W          = 9;
  localparam int Y_W          = 8;
  localparam int BG_ADDR_W    = 17;
  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;

  localparam logic [1:0] MODE_MOVE  = 2'd0;
  localparam logic [1:0] MODE_ERASE = 2'd1;
  localparam logic [1:0] MODE_DRAW  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    ERASE_FLUSH,
    DRAW,
    DONE
  } state_t;

endpackage

// File: rtl/token_move_renderer_footprint_scan.sv
// Raster counter over an SZ x SZ footprint: i runs fastest, j advances on i wrap.
module footprint_scan #(
  parameter int SZ = 4,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          en,
  output logic [CW-1:0] i,
  output logic [CW-1:0] j,
  output logic          last
);

  localparam logic [CW-1:0] MAX = CW'(SZ - 1);

  logic [CW-1:0] i_q, i_d;
  logic [CW-1:0] j_q, j_d;

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (start) begin
      i_d = '0;
      j_d = '0;
    end else if (en) begin
      if (i_q == MAX) begin
        i_d = '0;
        j_d = (j_q == MAX) ? '0 : j_q + 1'b1;
      end else begin
        i_d = i_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  assign i    = i_q;
  assign j    = j_q;
  assign last = (i_q == MAX) && (j_q == MAX);

endmodule

// File: rtl/token_move_renderer.sv
// Erases a token footprint from the background ROM and redraws it in the player colour.
// Optional TOKEN_ROUND_CORNER_EN skips the four footprint corners in both phases.
module token_move_renderer
  import token_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int PID_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  parameter int SZ          = 4,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int C_W         = 12,
  parameter logic [NUM_PLAYERS*C_W-1:0] PLAYER_COLORS = {12'hFF0, 12'h00F, 12'h0F0, 12'hF00}
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req,
  output logic                 ready,
  input  logic [1:0]           mode,
  input  logic [PID_W-1:0]     pid,
  input  logic [X_W-1:0]       old_x,
  input  logic [Y_W-1:0]       old_y,
  input  logic [X_W-1:0]       new_x,
  input  logic [Y_W-1:0]       new_y,
  output logic [BG_ADDR_W-1:0] bg_addr,
  input  logic [C_W-1:0]       bg_data,
  output logic [X_W-1:0]       x,
  output logic [Y_W-1:0]       y,
  output logic [C_W-1:0]       c,
  output logic                 plot,
  output logic                 done
);

  localparam int CW = (SZ > 1) ? $clog2(SZ) : 1;

  state_t           state_q, state_d;
  logic [PID_W-1:0] pid_q, pid_d;
  logic [1:0]       mode_q, mode_d;
  logic [X_W-1:0]   ox_q, ox_d, nx_q, nx_d, ex_q, ex_d;
  logic [Y_W-1:0]   oy_q, oy_d, ny_q, ny_d, ey_q, ey_d;
  logic             ep_q, ep_d;

  logic [CW-1:0]    i, j;
  logic             scan_start, scan_en, scan_last;
  logic [X_W-1:0]   base_x;
  logic [Y_W-1:0]   base_y;
  logic [X_W:0]     px;
  logic [Y_W:0]     py;
  logic             in_range, skip, pix_on;
  logic [BG_ADDR_W-1:0] addr;
  logic [C_W-1:0]   player_c;

  footprint_scan #(.SZ(SZ), .CW(CW)) u_scan (
    .clk   (clk),
    .resetn(resetn),
    .start (scan_start),
    .en    (scan_en),
    .i     (i),
    .j     (j),
    .last  (scan_last)
  );

`ifdef TOKEN_ROUND_CORNER_EN
  assign skip = ((i == '0) || (i == CW'(SZ - 1))) && ((j == '0) || (j == CW'(SZ - 1)));
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pid_d      = pid_q;
    mode_d     = mode_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    nx_d       = nx_q;
    ny_d       = ny_q;
    scan_start = 1'b0;
    scan_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          pid_d      = pid;
          mode_d     = mode;
          ox_d       = old_x;
          oy_d       = old_y;
          nx_d       = new_x;
          ny_d       = new_y;
          scan_start = 1'b1;
          case (mode)
            MODE_MOVE, MODE_ERASE: state_d = ERASE;
            MODE_DRAW:             state_d = DRAW;
            default:               state_d = ERASE;
          endcase
        end
      end
      ERASE: begin
        scan_en = 1'b1;
        if (scan_last) state_d = ERASE_FLUSH;
      end
      ERASE_FLUSH: begin
        scan_start = 1'b1;
        state_d    = (mode_q == MODE_ERASE) ? DONE : DRAW;
      end
      DRAW: begin
        scan_en = 1'b1;
        if (scan_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sums are one bit wider than the ports so off-screen pixels are detected, not wrapped.
  always_comb begin
    base_x   = (state_q == DRAW) ? nx_q : ox_q;
    base_y   = (state_q == DRAW) ? ny_q : oy_q;
    px       = {1'b0, base_x} + (X_W+1)'(i);
    py       = {1'b0, base_y} + (Y_W+1)'(j);
    in_range = (px < (X_W+1)'(SCREEN_W)) && (py < (Y_W+1)'(SCREEN_H));
    pix_on   = in_range && !skip;
    addr     = BG_ADDR_W'(py) * BG_ADDR_W'(SCREEN_W) + BG_ADDR_W'(px);
    ex_d     = px[X_W-1:0];
    ey_d     = py[Y_W-1:0];
    ep_d     = (state_q == ERASE) && pix_on;
    bg_addr  = ((state_q == ERASE) && in_range) ? addr : '0;
  end

  always_comb begin
    player_c = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (pid_q == PID_W'(p)) player_c = PLAYER_COLORS[p*C_W +: C_W];
    end
  end

  // Erase plots come one cycle after their ROM address; draw plots are immediate.
  always_comb begin
    ready = (state_q == IDLE);
    done  = (state_q == DONE);
    x     = '0;
    y     = '0;
    c     = '0;
    plot  = 1'b0;
    if (ep_q) begin
      x    = ex_q;
      y    = ey_q;
      c    = bg_data;
      plot = 1'b1;
    end else if (state_q == DRAW) begin
      x    = px[X_W-1:0];
      y    = py[Y_W-1:0];
      c    = player_c;
      plot = pix_on;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      pid_q   <= '0;
      mode_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      nx_q    <= '0;
      ny_q    <= '0;
      ex_q    <= '0;
      ey_q    <= '0;
      ep_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      mode_q  <= mode_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      ep_q    <= ep_d;
    end
  end

endmodule

// File: tb/tb_token_move_renderer.sv
// Directed, cycle-accurate bench for token_move_renderer (default and round-corner builds).
module tb_token_move_renderer;

  localparam logic [1:0] M_MOVE  = 2'd0;
  localparam logic [1:0] M_ERASE = 2'd1;
  localparam logic [1:0] M_DRAW  = 2'd2;
`ifdef TOKEN_ROUND_CORNER_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn, req, req2;
  logic [1:0]  mode, pid;
  logic [8:0]  old_x, new_x;
  logic [7:0]  old_y, new_y;
  logic [11:0] bg_data;
  logic [16:0] bg_addr, bg_addr2;
  logic [8:0]  x, x2;
  logic [7:0]  y, y2;
  logic [11:0] c, c2;
  logic        plot, plot2, ready, ready2, done, done2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Background ROM model: data is the low 12 bits of the address, one cycle late.
  always @(posedge clk) bg_data <= 12'(bg_addr);

  token_move_renderer dut (
    .clk(clk), .resetn(resetn), .req(req), .ready(ready), .mode(mode), .pid(pid),
    .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y),
    .bg_addr(bg_addr), .bg_data(bg_data), .x(x), .y(y), .c(c), .plot(plot), .done(done)
  );

  // A 2-bit id cannot exceed 4 players, so a 3-player instance exercises the out-of-range id.
  token_move_renderer #(.NUM_PLAYERS(3), .PLAYER_COLORS(36'h00F_0F0_F00)) dut3 (
    .clk(clk), .resetn(resetn), .req(req2), .ready(ready2), .mode(mode), .pid(pid),
    .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y),
    .bg_addr(bg_addr2), .bg_data(bg_data), .x(x2), .y(y2), .c(c2), .plot(plot2), .done(done2)
  );

  function automatic bit is_corner(input int k);
    return ROUND && ((k % 4 == 0) || (k % 4 == 3)) && ((k / 4 == 0) || (k / 4 == 3));
  endfunction

  function automatic logic [11:0] rom_val(input int px, input int py);
    int a;
    a = py * 320 + px;
    return a[11:0];
  endfunction

  // Presents a request at a negedge; returns #1 after the accept edge (cycle 1 is next).
  task automatic issue(input logic [1:0] m, input logic [1:0] p, input int ox, input int oy,
                       input int nx, input int ny, input bit use3, input bit hold);
    @(negedge clk);
    mode = m; pid = p;
    old_x = 9'(ox); old_y = 8'(oy); new_x = 9'(nx); new_y = 8'(ny);
    if (use3) req2 = 1'b1; else req = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin req = 1'b0; req2 = 1'b0; end
  endtask

  task automatic test_reset();
    resetn = 1'b0; req = 1'b0; req2 = 1'b0; mode = '0; pid = '0;
    old_x = '0; old_y = '0; new_x = '0; new_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (ready !== 1'b1) $display("[TB] FAIL reset_ready got=%b want=1", ready); else n_pass++;
    n_chk++; if (plot !== 1'b0) $display("[TB] FAIL reset_plot got=%b want=0", plot); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("[TB] FAIL reset_done got=%b want=0", done); else n_pass++;
    n_chk++; if ({x, y, c} !== '0) $display("[TB] FAIL reset_xyc got=%0d,%0d,%h want=0,0,0", x, y, c); else n_pass++;
    n_chk++; if (bg_addr !== '0) $display("[TB] FAIL reset_bg_addr got=%0d want=0", bg_addr); else n_pass++;
    resetn = 1'b1;
  endtask

  task automatic test_move();
    int k, ex, ey;
    bit ep;
    logic [11:0] ec;
    issue(M_MOVE, 2'd1, 10, 20, 14, 20, 1'b0, 1'b0);
    for (int cyc = 1; cyc <= 36; cyc++) begin
      @(negedge clk);
      ep = 1'b0; ex = 0; ey = 0; ec = '0;
      if (cyc <= 16) begin
        k = cyc - 1;
        n_chk++;
        if (bg_addr !== 17'((20 + k / 4) * 320 + 10 + k % 4))
          $display("[TB] FAIL move_bg_addr cyc=%0d got=%0d want=%0d", cyc, bg_addr, (20 + k / 4) * 320 + 10 + k % 4);
        else n_pass++;
      end
      if (cyc >= 2 && cyc <= 17) begin
        k = cyc - 2; ex = 10 + k % 4; ey = 20 + k / 4; ec = rom_val(ex, ey); ep = !is_corner(k);
      end else if (cyc >= 18 && cyc <= 33) begin
        k = cyc - 18; ex = 14 + k % 4; ey = 20 + k / 4; ec = 12'h0F0; ep = !is_corner(k);
      end
      n_chk++; if (plot !== ep) $display("[TB] FAIL move_plot cyc=%0d got=%b want=%b", cyc, plot, ep); else n_pass++;
      if (ep) begin
        n_chk++;
        if (x !== 9'(ex) || y !== 8'(ey) || c !== ec)
          $display("[TB] FAIL move_pixel cyc=%0d got=%0d,%0d,%h want=%0d,%0d,%h", cyc, x, y, c, ex, ey, ec);
        else n_pass++;
      end
      n_chk++; if (done !== (cyc == 34)) $display("[TB] FAIL move_done cyc=%0d got=%b", cyc, done); else n_pass++;
      n_chk++; if (ready !== (cyc >= 35)) $display("[TB] FAIL move_ready cyc=%0d got=%b", cyc, ready); else n_pass++;
    end
  endtask

  task automatic test_edge_draw();
    int k, ex, ey;
    bit ep;
    issue(M_DRAW, 2'd3, 0, 0, 318, 238, 1'b0, 1'b0);
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(negedge clk);
      k = cyc - 1; ex = 318 + k % 4; ey = 238 + k / 4;
      ep = (cyc <= 16) && ex < 320 && ey < 240 && !is_corner(k);
      n_chk++; if (plot !== ep) $display("[TB] FAIL edge_plot cyc=%0d got=%b want=%b", cyc, plot, ep); else n_pass++;
      if (ep) begin
        n_chk++;
        if (x !== 9'(ex) || y !== 8'(ey) || c !== 12'hFF0)
          $display("[TB] FAIL edge_pixel cyc=%0d got=%0d,%0d,%h want=%0d,%0d,ff0", cyc, x, y, c, ex, ey);
        else n_pass++;
      end
      n_chk++; if (done !== (cyc == 17)) $display("[TB] FAIL edge_done cyc=%0d got=%b", cyc, done); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int bad_ready = 0;
    int done_cyc = 0;
    issue(M_MOVE, 2'd0, 0, 0, 4, 0, 1'b0, 1'b1);
    mode = M_DRAW; pid = 2'd2; new_x = 9'd100; new_y = 8'd50;
    for (int cyc = 1; cyc <= 35; cyc++) begin
      @(negedge clk);
      if (cyc <= 34 && ready) bad_ready++;
      if (done && done_cyc == 0) done_cyc = cyc;
      if (cyc == 19) begin
        n_chk++;
        if (plot !== 1'b1 || x !== 9'd5 || y !== 8'd0 || c !== 12'hF00)
          $display("[TB] FAIL b2b_latched plot=%b got=%0d,%0d,%h want=5,0,f00", plot, x, y, c);
        else n_pass++;
      end
      if (cyc == 35) begin
        n_chk++; if (ready !== 1'b1) $display("[TB] FAIL b2b_ready_return got=%b want=1", ready); else n_pass++;
      end
    end
    n_chk++; if (bad_ready != 0) $display("[TB] FAIL b2b_busy_ready got=%0d want=0", bad_ready); else n_pass++;
    n_chk++; if (done_cyc != 34) $display("[TB] FAIL b2b_first_done got=%0d want=34", done_cyc); else n_pass++;
    @(posedge clk);
    #1;
    req = 1'b0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(negedge clk);
      if (done && done_cyc == 0) done_cyc = cyc;
      if (cyc == 1) begin
        n_chk++; if (ready !== 1'b0) $display("[TB] FAIL b2b_second_accept ready=%b want=0", ready); else n_pass++;
      end
      if (cyc == 2) begin
        n_chk++;
        if (plot !== 1'b1 || x !== 9'd101 || y !== 8'd50 || c !== 12'h00F)
          $display("[TB] FAIL b2b_second_pixel plot=%b got=%0d,%0d,%h want=101,50,00f", plot, x, y, c);
        else n_pass++;
      end
    end
    n_chk++; if (done_cyc != 17) $display("[TB] FAIL b2b_second_done got=%0d want=17", done_cyc); else n_pass++;
  endtask

  task automatic test_reset_mid_draw();
    int k, ex, ey;
    bit ep;
    bit done_seen = 1'b0;
    issue(M_DRAW, 2'd1, 0, 0, 50, 60, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    n_chk++;
    if (plot !== 1'b1 || x !== 9'd51 || y !== 8'd61)
      $display("[TB] FAIL rst_pixel5 plot=%b got=%0d,%0d want=51,61", plot, x, y);
    else n_pass++;
    resetn = 1'b0;
    @(negedge clk);
    n_chk++;
    if (plot !== 1'b0 || ready !== 1'b1 || done !== 1'b0)
      $display("[TB] FAIL rst_state got plot=%b ready=%b done=%b want 0,1,0", plot, ready, done);
    else n_pass++;
    resetn = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    n_chk++; if (done_seen !== 1'b0) $display("[TB] FAIL rst_no_done got=%b want=0", done_seen); else n_pass++;
    issue(M_ERASE, 2'd0, 200, 100, 0, 0, 1'b0, 1'b0);
    for (int cyc = 1; cyc <= 19; cyc++) begin
      @(negedge clk);
      k = cyc - 2; ex = 200 + k % 4; ey = 100 + k / 4;
      ep = (cyc >= 2 && cyc <= 17) && !is_corner(k);
      n_chk++; if (plot !== ep) $display("[TB] FAIL erase_plot cyc=%0d got=%b want=%b", cyc, plot, ep); else n_pass++;
      if (ep) begin
        n_chk++;
        if (x !== 9'(ex) || y !== 8'(ey) || c !== rom_val(ex, ey))
          $display("[TB] FAIL erase_pixel cyc=%0d got=%0d,%0d,%h want=%0d,%0d,%h", cyc, x, y, c, ex, ey, rom_val(ex, ey));
        else n_pass++;
      end
      n_chk++; if (done !== (cyc == 18)) $display("[TB] FAIL erase_done cyc=%0d got=%b", cyc, done); else n_pass++;
    end
  endtask

  task automatic test_oor_pid();
    int k;
    bit ep;
    issue(M_DRAW, 2'd3, 0, 0, 30, 30, 1'b1, 1'b0);
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(negedge clk);
      k = cyc - 1;
      ep = (cyc <= 16) && !is_corner(k);
      n_chk++; if (plot2 !== ep) $display("[TB] FAIL oor_plot cyc=%0d got=%b want=%b", cyc, plot2, ep); else n_pass++;
      if (ep) begin
        n_chk++;
        if (c2 !== 12'h000 || x2 !== 9'(30 + k % 4) || y2 !== 8'(30 + k / 4))
          $display("[TB] FAIL oor_pixel cyc=%0d got=%0d,%0d,%h want=%0d,%0d,000", cyc, x2, y2, c2, 30 + k % 4, 30 + k / 4);
        else n_pass++;
      end
      n_chk++; if (done2 !== (cyc == 17)) $display("[TB] FAIL oor_done cyc=%0d got=%b", cyc, done2); else n_pass++;
      n_chk++; if (bg_addr2 !== '0) $display("[TB] FAIL oor_bg_addr cyc=%0d got=%0d want=0", cyc, bg_addr2); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_move();
    test_edge_draw();
    test_back_to_back();
    test_reset_mid_draw();
    test_oor_pid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
